// File: rtl/l1_cache_param_if.sv
// Requester and memory-bus signal bundle for l1_cache_param.
`timescale 1ns/1ps
interface l1_cache_param_if #(
  parameter int TAG_W  = 4,
  parameter int DATA_W = 8
);
  logic                    read;
  logic                    flush;
  logic [TAG_W-1:0]        ID;
  logic [DATA_W-1:0]       data_out;
  logic                    done;
  logic                    bus_start;
  logic [TAG_W-1:0]        bus_id;
  logic [TAG_W+DATA_W-1:0] bus_in;
  logic                    bus_done;

  // Cache side.
  modport slave (
    input  read, flush, ID, bus_in, bus_done,
    output data_out, done, bus_start, bus_id
  );

  // Requester / memory model side.
  modport master (
    output read, flush, ID, bus_in, bus_done,
    input  data_out, done, bus_start, bus_id
  );
endinterface

// File: rtl/l1_cache_param.sv
// Fully-associative read-only L1 cache, round-robin replacement, flush and tag-checked fills.
// Optional hit/miss counters enabled by defining L1_STATS_EN.
`timescale 1ns/1ps
module l1_cache_param #(
  parameter int TAG_W   = 4,
  parameter int DATA_W  = 8,
  parameter int ENTRIES = 4
) (
  input  logic              clk,
  input  logic              reset,
  l1_cache_param_if.slave   cif
`ifdef L1_STATS_EN
  ,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);

  typedef enum logic [1:0] {IDLE, LOOKUP, REQ, FILL} state_t;

  state_t state, state_nx;

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag_arr  [ENTRIES];
  logic [DATA_W-1:0]  data_arr [ENTRIES];
  logic [IDX_W-1:0]   rr_ptr;

  logic [TAG_W-1:0]   req_tag;
  logic [TAG_W-1:0]   fill_tag;
  logic [DATA_W-1:0]  fill_data;

  logic [DATA_W-1:0]  data_out_r;
  logic               done_r;
  logic               bus_start_r;
  logic [TAG_W-1:0]   bus_id_r;

  logic               hit;
  logic [IDX_W-1:0]   hit_idx;
  logic               has_free;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   victim;
  logic               resp_ok;

  assign cif.data_out  = data_out_r;
  assign cif.done      = done_r;
  assign cif.bus_start = bus_start_r;
  assign cif.bus_id    = bus_id_r;

  // Descending scans so the lowest matching / free index is the one kept.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    has_free = 1'b0;
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid[i] && (tag_arr[i] == req_tag)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!valid[i]) begin
        has_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign victim  = has_free ? free_idx : rr_ptr;
  assign resp_ok = cif.bus_done && (cif.bus_in[TAG_W+DATA_W-1 -: TAG_W] == req_tag);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (!cif.flush && cif.read) state_nx = LOOKUP;
      LOOKUP:  state_nx = hit ? IDLE : REQ;
      REQ:     if (resp_ok) state_nx = FILL;
      FILL:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Control state and outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid       <= '0;
      rr_ptr      <= '0;
      data_out_r  <= '0;
      done_r      <= 1'b0;
      bus_start_r <= 1'b0;
      bus_id_r    <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (cif.flush) valid <= '0;
        end
        LOOKUP: begin
          if (hit) begin
            data_out_r <= data_arr[hit_idx];
            done_r     <= 1'b1;
          end else begin
            bus_start_r <= 1'b1;
            bus_id_r    <= req_tag;
          end
        end
        REQ: begin
          if (resp_ok) bus_start_r <= 1'b0;
        end
        FILL: begin
          valid[victim] <= 1'b1;
          if (!has_free) rr_ptr <= rr_ptr + 1'b1;
          data_out_r <= fill_data;
          done_r     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Storage and capture registers carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (state == IDLE && !cif.flush && cif.read) req_tag <= cif.ID;
    if (state == REQ && resp_ok) begin
      fill_tag  <= cif.bus_in[TAG_W+DATA_W-1 -: TAG_W];
      fill_data <= cif.bus_in[DATA_W-1:0];
    end
    if (state == FILL) begin
      tag_arr[victim]  <= fill_tag;
      data_arr[victim] <= fill_data;
    end
  end

`ifdef L1_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == LOOKUP) begin
      if (hit && hit_count != 16'hFFFF)        hit_count  <= hit_count + 16'd1;
      else if (!hit && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_l1_cache_param.sv
// Bench for l1_cache_param: directed vector table, reset-in-REQ sequence, random reads vs a line-set model.
`timescale 1ns/1ps
module tb_l1_cache_param;
  localparam int TAG_W  = 4;
  localparam int DATA_W = 8;
  localparam int N      = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  l1_cache_param_if #(.TAG_W(TAG_W), .DATA_W(DATA_W)) ifc ();

`ifdef L1_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  l1_cache_param #(.TAG_W(TAG_W), .DATA_W(DATA_W), .ENTRIES(N)) dut (
    .clk   (clk),
    .reset (reset),
    .cif   (ifc)
`ifdef L1_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Backing memory and the expected cache contents as a set of resident lines.
  logic [7:0] mem     [16];
  bit         m_valid [N];
  logic [3:0] m_tag   [N];
  int         m_rr;
  int         exp_hits;
  int         exp_misses;

  typedef struct {
    int         op;      // 0 read, 1 flush, 2 flush together with read
    logic [3:0] tag;
    int         wrong;   // stray-tag responses before the real one
    int         dly;     // idle cycles of bus_start before responding
    bit         exp_hit;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_valid[i] = 0;
    m_rr = 0;
    exp_hits = 0;
    exp_misses = 0;
  endtask

  task automatic model_flush();
    for (int i = 0; i < N; i++) m_valid[i] = 0;
  endtask

  task automatic model_read(input logic [3:0] t, output bit h);
    int v;
    h = 0;
    for (int i = 0; i < N; i++) if (m_valid[i] && m_tag[i] == t) h = 1;
    if (h) begin
      exp_hits++;
    end else begin
      exp_misses++;
      v = -1;
      for (int i = N - 1; i >= 0; i--) if (!m_valid[i]) v = i;
      if (v < 0) begin
        v = m_rr;
        m_rr = (m_rr + 1) % N;
      end
      m_valid[v] = 1;
      m_tag[v] = t;
    end
  endtask

  task automatic do_read(input logic [3:0] t, input int wrong, input int dly,
                         input bit exp_hit, input string nm);
    int w, wl, lat;
    bit saw_bus, got, pend_wrong;
    logic [7:0] d;
    @(negedge clk);
    ifc.read = 1'b1;
    ifc.ID   = t;
    @(negedge clk);
    ifc.read = 1'b0;
    ifc.ID   = 4'($urandom);
    w = 0; wl = wrong; lat = -1; saw_bus = 0; got = 0; pend_wrong = 0; d = '0;
    for (int n = 0; n < 80 && !got; n++) begin
      ifc.bus_done = 1'b0;
      if (pend_wrong) begin
        chk({nm, " bus_start held after stray tag"}, ifc.bus_start, 1);
        pend_wrong = 0;
      end
      if (ifc.done) begin
        got = 1; lat = n; d = ifc.data_out;
      end else if (ifc.bus_start) begin
        if (!saw_bus) chk({nm, " bus_id"}, ifc.bus_id, t);
        saw_bus = 1;
        if (w < dly) begin
          w++;
        end else if (wl > 0) begin
          ifc.bus_done = 1'b1;
          ifc.bus_in   = {t + 4'd1, ~mem[t]};
          wl--;
          pend_wrong = 1;
        end else begin
          ifc.bus_done = 1'b1;
          ifc.bus_in   = {t, mem[t]};
        end
      end
      if (!got) @(negedge clk);
    end
    chk({nm, " done seen"}, got, 1);
    chk({nm, " bus request on miss only"}, saw_bus, !exp_hit);
    chk({nm, " data_out"}, d, mem[t]);
    chk({nm, " latency"}, lat, exp_hit ? 1 : 3 + dly + wrong);
    @(negedge clk);
    chk({nm, " done one cycle"}, ifc.done, 0);
    chk({nm, " data_out held"}, ifc.data_out, mem[t]);
`ifdef L1_STATS_EN
    chk({nm, " hit_count"}, hit_count, exp_hits);
    chk({nm, " miss_count"}, miss_count, exp_misses);
`endif
  endtask

  task automatic do_flush(input bit with_read, input logic [3:0] t, input string nm);
    @(negedge clk);
    ifc.flush = 1'b1;
    ifc.read  = with_read;
    ifc.ID    = t;
    @(negedge clk);
    ifc.flush = 1'b0;
    ifc.read  = 1'b0;
    if (with_read) begin
      for (int k = 0; k < 4; k++) begin
        chk({nm, " read ignored: done"}, ifc.done, 0);
        chk({nm, " read ignored: bus_start"}, ifc.bus_start, 0);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit h, saw;
    int r;
    logic [3:0] t;

    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    mem[3] = 8'hA5;
    mem[9] = 8'h5C;
    model_reset();

    ifc.read = 1'b0; ifc.flush = 1'b0; ifc.ID = '0;
    ifc.bus_in = '0; ifc.bus_done = 1'b0;

    tbl[0]  = '{0, 4'h3, 0, 3, 0};
    tbl[1]  = '{0, 4'h3, 0, 0, 1};
    tbl[2]  = '{1, 4'h0, 0, 0, 0};
    tbl[3]  = '{0, 4'h1, 0, 0, 0};
    tbl[4]  = '{0, 4'h2, 0, 1, 0};
    tbl[5]  = '{0, 4'h3, 0, 0, 0};
    tbl[6]  = '{0, 4'h4, 0, 2, 0};
    tbl[7]  = '{0, 4'h5, 0, 0, 0};   // all lines valid: evicts line 0 (tag 1)
    tbl[8]  = '{0, 4'h1, 0, 0, 0};   // evicts line 1 (tag 2)
    tbl[9]  = '{0, 4'h3, 0, 0, 1};
    tbl[10] = '{0, 4'h2, 0, 0, 0};
    tbl[11] = '{0, 4'h6, 2, 1, 0};   // two tag-7 responses ignored first
    tbl[12] = '{0, 4'h9, 0, 0, 0};
    tbl[13] = '{2, 4'h9, 0, 0, 0};
    tbl[14] = '{0, 4'h9, 0, 0, 0};

    repeat (3) @(negedge clk);
    chk("reset done", ifc.done, 0);
    chk("reset bus_start", ifc.bus_start, 0);
    chk("reset bus_id", ifc.bus_id, 0);
    chk("reset data_out", ifc.data_out, 0);
`ifdef L1_STATS_EN
    chk("reset hit_count", hit_count, 0);
    chk("reset miss_count", miss_count, 0);
`endif
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      case (tbl[i].op)
        0: begin
          model_read(tbl[i].tag, h);
          do_read(tbl[i].tag, tbl[i].wrong, tbl[i].dly, tbl[i].exp_hit,
                  $sformatf("vec%0d", i));
        end
        1: begin
          model_flush();
          do_flush(0, tbl[i].tag, $sformatf("vec%0d", i));
        end
        default: begin
          model_flush();
          do_flush(1, tbl[i].tag, $sformatf("vec%0d", i));
        end
      endcase
    end

    // Reset while a miss is outstanding.
    @(negedge clk);
    ifc.read = 1'b1; ifc.ID = 4'hA;
    @(negedge clk);
    ifc.read = 1'b0;
    saw = 0;
    for (int k = 0; k < 10 && !saw; k++) begin
      if (ifc.bus_start) saw = 1;
      else @(negedge clk);
    end
    chk("rst_req bus_start reached", saw, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_req bus_start", ifc.bus_start, 0);
    chk("rst_req done", ifc.done, 0);
    chk("rst_req data_out", ifc.data_out, 0);
`ifdef L1_STATS_EN
    chk("rst_req hit_count", hit_count, 0);
    chk("rst_req miss_count", miss_count, 0);
`endif
    reset = 1'b0;
    model_reset();
    model_read(4'h9, h);
    do_read(4'h9, 0, 0, h, "after_rst tag9");
    model_read(4'h2, h);
    do_read(4'h2, 0, 1, h, "after_rst tag2");

    // Random traffic over a small tag space so hits and evictions both occur.
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        model_flush();
        do_flush(0, 4'h0, $sformatf("rnd%0d flush", i));
      end else begin
        t = 4'($urandom_range(0, 7));
        model_read(t, h);
        do_read(t, $urandom_range(0, 1), $urandom_range(0, 3), h,
                $sformatf("rnd%0d tag%0h", i, t));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
